pwm_spi_bridge: RTL and testbench
=================================

# pwm_spi_bridge

SPI slave front-end that turns 16-bit serial frames from an external MCU into single-cycle parallel register-bus accesses. It sits directly upstream of the PWM peripheral's register file, driving its write-enable, read-enable, address and bidirectional data lines. It also returns read data on MISO. SPI pins are asynchronous to `i_clk` and are oversampled through synchronisers.

## Interface
- `ADDRESS_WIDTH`, 6, register-bus address width (frame bits 13:8).
- `DATA_WIDTH`, 8, register-bus data width; fixed at 8.
- `SYNC_STAGES`, 2, flip-flop stages on `i_sclk`, `i_cs_n` and `i_mosi`.
- `i_clk  input  1  system clock; one clock domain.`
- `i_reset_n  input  1  asynchronous, active-low reset.`
- `i_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), max f(i_clk)/16.`
- `i_cs_n  input  1  SPI chip select, active low.`
- `i_mosi  input  1  SPI data in, MSB first.`
- `o_miso  output  1  SPI data out, MSB first.`
- `o_miso_oe  output  1  high while i_cs_n (synchronised) is low; pad tri-state control.`
- `o_write_en  output  1  one-cycle write strobe to register file.`
- `o_read_en  output  1  read strobe, two cycles.`
- `o_address  output  ADDRESS_WIDTH  bus address; held from capture until next frame.`
- `io_data  inout  DATA_WIDTH  bus data; driven only while o_write_en=1, else Z.`
- `o_busy  output  1  high from CS fall (synchronised) to return to IDLE.`
- `o_frame_err  output  1  one-cycle pulse on CS rise with fewer than 16 bits received.`

## Operation
- Frame: bit15 = R/W (1 write, 0 read), bit14 reserved/ignored, bits13:8 address, bits7:0 write data (ignored on read).
- Edge detect on synchronised SCLK: sample MOSI on rising edge, shift MISO on falling edge; 5-bit bit counter saturates at 16.
- MISO: first byte is constant 0xA5 (link check). Second byte is read data for reads, 0x00 for writes. Bits beyond 16 are 0.
- On CS fall detect: load MISO shift register with 0xA5 and present bit7 on o_miso.
- FSM states:
  - IDLE: wait for CS fall → CMD.
  - CMD: shift bits 15..8; after the 8th rising edge latch o_address. Go to RD_ACCESS if R/W=0, else DATA.
  - RD_ACCESS: o_read_en=1 for exactly 2 cycles; sample io_data in the 2nd cycle; load it into the MISO shift register (present bit7 on next falling edge) → DATA.
  - DATA: shift bits 7..0; after the 16th rising edge → WR if write, else DONE.
  - WR: o_write_en=1, io_data driven with received byte, one cycle → DONE.
  - DONE: ignore further SCLK; wait CS rise.
- CS rise in any non-IDLE state → IDLE next cycle, with:
  - o_frame_err pulsed if the bit count is below 16.
  - No write issued for an aborted frame.
  - o_read_en dropped immediately if aborted in RD_ACCESS.
- Write is committed at the 16th edge and does not wait for CS rise. Frames longer than 16 bits give exactly one access.

## Timing
- Reset: o_miso=0, o_miso_oe=0, o_write_en=0, o_read_en=0, o_address=0, io_data=Z, o_busy=0, o_frame_err=0, FSM=IDLE, counters 0.
- Input latency: SYNC_STAGES+1 i_clk cycles from pin edge to internal edge pulse.
- Write latency: o_write_en asserted SYNC_STAGES+2 cycles after 16th SCLK rising edge at pin.
- Read: o_read_en asserted SYNC_STAGES+2 cycles after the 8th rising edge; data on MISO by the following falling edge. Guaranteed by SCLK half-period ≥ 8 i_clk.
- Setup requirements: CS fall to first SCLK rise ≥ 8 i_clk; CS high time between frames ≥ 4 i_clk.
- Reset mid-frame: all outputs to reset values immediately; bridge stays IDLE until next CS fall after reset release; the partial frame is discarded.

## Test plan
- Write frame 0x81,0x3C: one o_write_en pulse, o_address=0x01, io_data=0x3C in that cycle; MISO returns 0xA5,0x00; no read strobe.
- Read frame 0x05,0xFF with register model returning 0x5A: o_read_en high exactly 2 cycles, o_address=0x05; MISO returns 0xA5,0x5A; no write.
- Write frame aborted after 12 bits: no o_write_en; o_frame_err pulses once on CS rise; o_busy drops.
- 24-bit write frame 0xBF,0x77,0xFF: exactly one write to address 0x3F data 0x77; MISO bits 16..23 = 0; no o_frame_err.
- Reset asserted during DATA of a write: outputs at reset values, io_data=Z, no write. A following full frame 0x82,0x11 writes 0x11 to address 0x02.
- Back-to-back frames with 4-cycle CS gap at SCLK = f(i_clk)/16 (write 0x83,0xAA, then read 0x03): read returns 0xAA via model; no frame errors.

Source files
------------

// File: rtl/pwm_spi_bridge_if.sv
// ---------------------------------------------------------------------------
// pwm_spi_bridge_if : SPI pin bundle between the MCU and the bridge
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pwm_spi_bridge_if;
   logic i_sclk;
   logic i_cs_n;
   logic i_mosi;
   logic o_miso;
   logic o_miso_oe;

   modport slave  (input  i_sclk, i_cs_n, i_mosi, output o_miso, o_miso_oe);
   modport master (output i_sclk, i_cs_n, i_mosi, input  o_miso, o_miso_oe);
endinterface

`default_nettype wire

// File: rtl/pwm_spi_bridge.sv
// ---------------------------------------------------------------------------
// pwm_spi_bridge : 16-bit SPI mode-0 slave to single-cycle register bus
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_spi_bridge #(
   parameter int ADDRESS_WIDTH = 6,
   parameter int DATA_WIDTH    = 8,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   pwm_spi_bridge_if.slave          spi,
   output logic                     o_write_en,
   output logic                     o_read_en,
   output logic [ADDRESS_WIDTH-1:0] o_address,
   inout  wire  [DATA_WIDTH-1:0]    io_data,
   output logic                     o_busy,
   output logic                     o_frame_err
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CMD       = 3'd1;
   localparam logic [2:0] ST_RD_ACCESS = 3'd2;
   localparam logic [2:0] ST_DATA      = 3'd3;
   localparam logic [2:0] ST_WR        = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;

   localparam logic [DATA_WIDTH-1:0] LINK_BYTE = 8'hA5;

   logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0]   cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
   logic                     sclk_s, cs_s, mosi_s;

   logic                     sclk_prev_q, sclk_prev_d;
   logic                     cs_prev_q,   cs_prev_d;
   logic                     armed_q,     armed_d;
   logic                     rise_q,      rise_d;
   logic                     fall_q,      fall_d;
   logic                     cs_fall_q,   cs_fall_d;
   logic                     cs_rise_q,   cs_rise_d;
   logic                     mosi_q,      mosi_d;

   logic [2:0]               state_q,     state_d;
   logic [4:0]               bit_cnt_q,   bit_cnt_d;
   logic [DATA_WIDTH-1:0]    rx_q,        rx_d;
   logic [DATA_WIDTH-1:0]    rx_shift;
   logic                     rw_q,        rw_d;
   logic [ADDRESS_WIDTH-1:0] address_q,   address_d;
   logic [DATA_WIDTH-1:0]    wdata_q,     wdata_d;
   logic                     rd_phase_q,  rd_phase_d;
   logic                     miso_bit_q,  miso_bit_d;
   logic [DATA_WIDTH-1:0]    miso_sr_q,   miso_sr_d;
   logic                     frame_err_q, frame_err_d;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // The CS chain resets low and CS edges are only honoured once CS has been
   // seen high, so a frame already in flight at reset release is ignored.
   always_comb begin
      sclk_sync_d = (sclk_sync_q << 1) | SYNC_STAGES'(spi.i_sclk);
      cs_sync_d   = (cs_sync_q   << 1) | SYNC_STAGES'(spi.i_cs_n);
      mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(spi.i_mosi);
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;
      armed_d     = armed_q | cs_s;
      rise_d      = sclk_s & ~sclk_prev_q;
      fall_d      = ~sclk_s & sclk_prev_q;
      cs_fall_d   = ~cs_s & cs_prev_q & armed_q;
      cs_rise_d   = cs_s & ~cs_prev_q;
      mosi_d      = mosi_s;
   end

   assign rx_shift = {rx_q[DATA_WIDTH-2:0], mosi_q};

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      rw_d        = rw_q;
      address_d   = address_q;
      wdata_d     = wdata_q;
      rd_phase_d  = rd_phase_q;
      miso_bit_d  = miso_bit_q;
      miso_sr_d   = miso_sr_q;
      frame_err_d = 1'b0;

      if (state_q != ST_IDLE) begin
         if (fall_q) begin
            miso_bit_d = miso_sr_q[DATA_WIDTH-1];
            miso_sr_d  = {miso_sr_q[DATA_WIDTH-2:0], 1'b0};
         end
         if (rise_q) begin
            bit_cnt_d = (bit_cnt_q == 5'd16) ? 5'd16 : bit_cnt_q + 5'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall_q) begin
               state_d    = ST_CMD;
               bit_cnt_d  = 5'd0;
               rx_d       = '0;
               miso_bit_d = LINK_BYTE[DATA_WIDTH-1];
               miso_sr_d  = {LINK_BYTE[DATA_WIDTH-2:0], 1'b0};
            end
         end
         ST_CMD: begin
            if (rise_q) begin
               rx_d = rx_shift;
               if (bit_cnt_q == 5'd7) begin
                  address_d  = rx_shift[ADDRESS_WIDTH-1:0];
                  rw_d       = rx_shift[DATA_WIDTH-1];
                  rd_phase_d = 1'b0;
                  state_d    = rx_shift[DATA_WIDTH-1] ? ST_DATA : ST_RD_ACCESS;
               end
            end
         end
         ST_RD_ACCESS: begin
            rd_phase_d = 1'b1;
            if (rd_phase_q) begin
               miso_sr_d = io_data;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rise_q) begin
               rx_d = rx_shift;
               if (bit_cnt_q == 5'd15) begin
                  wdata_d = rx_shift;
                  state_d = rw_q ? ST_WR : ST_DONE;
               end
            end
         end
         ST_WR:   state_d = ST_DONE;
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase

      // CS rise aborts from anywhere; a short frame never reaches ST_WR.
      if (state_q != ST_IDLE && cs_rise_q) begin
         state_d     = ST_IDLE;
         frame_err_d = (bit_cnt_q < 5'd16);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b0;
         armed_q     <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
         mosi_q      <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 5'd0;
         rx_q        <= '0;
         rw_q        <= 1'b0;
         address_q   <= '0;
         wdata_q     <= '0;
         rd_phase_q  <= 1'b0;
         miso_bit_q  <= 1'b0;
         miso_sr_q   <= '0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         armed_q     <= armed_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         cs_fall_q   <= cs_fall_d;
         cs_rise_q   <= cs_rise_d;
         mosi_q      <= mosi_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         rw_q        <= rw_d;
         address_q   <= address_d;
         wdata_q     <= wdata_d;
         rd_phase_q  <= rd_phase_d;
         miso_bit_q  <= miso_bit_d;
         miso_sr_q   <= miso_sr_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_write_en    = (state_q == ST_WR);
   assign o_read_en     = (state_q == ST_RD_ACCESS) & ~cs_rise_q;
   assign o_address     = address_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_frame_err   = frame_err_q;
   assign io_data       = o_write_en ? wdata_q : {DATA_WIDTH{1'bz}};
   assign spi.o_miso    = miso_bit_q;
   assign spi.o_miso_oe = ~cs_s & armed_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_spi_bridge.sv
// ---------------------------------------------------------------------------
// tb_pwm_spi_bridge : directed frames against a 64-entry register model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_spi_bridge;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       write_en, read_en, busy, frame_err;
   logic [5:0] address;
   wire  [7:0] io_data;

   pwm_spi_bridge_if spi ();

   pwm_spi_bridge #(.ADDRESS_WIDTH(6), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .spi         (spi),
      .o_write_en  (write_en),
      .o_read_en   (read_en),
      .o_address   (address),
      .io_data     (io_data),
      .o_busy      (busy),
      .o_frame_err (frame_err)
   );

   logic [7:0] mem [64];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
         mem[5] <= 8'h5A;
      end else if (write_en) begin
         mem[address] <= io_data;
      end
   end
   assign io_data = read_en ? mem[address] : 8'bz;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         wr_cnt = 0, rd_cnt = 0, fe_cnt = 0, wr_cyc = 0, rd_cyc = 0;
   logic [7:0] wr_data = 8'h00;
   logic [5:0] wr_addr = 6'h00;
   logic       wr_prev = 1'b0, rd_prev = 1'b0;
   always @(negedge clk) begin
      if (write_en) begin
         wr_cnt  = wr_cnt + 1;
         wr_addr = address;
         wr_data = io_data;
         if (!wr_prev) wr_cyc = cyc;
      end
      if (read_en) begin
         rd_cnt = rd_cnt + 1;
         if (!rd_prev) rd_cyc = cyc;
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
      wr_prev = write_en;
      rd_prev = read_en;
   end

   int nvec = 0, nerr = 0;
   int r8 = 0, r16 = 0;
   int wr_b = 0, rd_b = 0, fe_b = 0;
   logic [23:0] m, m1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      wr_b = wr_cnt;
      rd_b = rd_cnt;
      fe_b = fe_cnt;
   endtask

   // Mode 0: sample MISO and raise SCLK together, change MOSI on the fall.
   task automatic spi_clock(input int n, input logic [23:0] d, output logic [23:0] mo);
      mo = 24'h0;
      spi.i_mosi = d[n-1];
      for (int i = 0; i < n; i++) begin
         mo = {mo[22:0], spi.o_miso};
         spi.i_sclk = 1'b1;
         if (i == 7)  r8  = cyc;
         if (i == 15) r16 = cyc;
         ticks(8);
         spi.i_sclk = 1'b0;
         if (i < n - 1) spi.i_mosi = d[n-2-i];
         ticks(8);
      end
   endtask

   task automatic spi_frame(input int n, input logic [23:0] d, input int gap,
                            output logic [23:0] mo);
      spi.i_cs_n = 1'b0;
      spi.i_mosi = d[n-1];
      ticks(8);
      spi_clock(n, d, mo);
      spi.i_cs_n = 1'b1;
      ticks(gap);
   endtask

   initial begin
      rst_n      = 1'b0;
      spi.i_sclk = 1'b0;
      spi.i_cs_n = 1'b1;
      spi.i_mosi = 1'b0;
      ticks(3);
      check("rst_write_en", {31'd0, write_en}, 32'd0);
      check("rst_read_en",  {31'd0, read_en},  32'd0);
      check("rst_address",  {26'd0, address},  32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_miso",     {31'd0, spi.o_miso},    32'd0);
      check("rst_miso_oe",  {31'd0, spi.o_miso_oe}, 32'd0);
      check("rst_frame_err",{31'd0, frame_err}, 32'd0);
      rst_n = 1'b1;
      ticks(8);

      // write 0x81,0x3C
      snap();
      spi_frame(16, 24'h813C, 10, m);
      check("wr_pulses",  wr_cnt - wr_b, 1);
      check("wr_addr",    {26'd0, wr_addr}, 32'h01);
      check("wr_data",    {24'd0, wr_data}, 32'h3C);
      check("wr_latency", wr_cyc - r16, 4);
      check("wr_miso",    {16'd0, m[15:0]}, 32'hA500);
      check("wr_no_read", rd_cnt - rd_b, 0);
      check("wr_no_ferr", fe_cnt - fe_b, 0);
      check("wr_busy_end",{31'd0, busy}, 32'd0);

      // read 0x05 with model returning 0x5A
      snap();
      spi_frame(16, 24'h05FF, 10, m);
      check("rd_cycles",   rd_cnt - rd_b, 2);
      check("rd_latency",  rd_cyc - r8, 4);
      check("rd_address",  {26'd0, address}, 32'h05);
      check("rd_miso",     {16'd0, m[15:0]}, 32'hA55A);
      check("rd_no_write", wr_cnt - wr_b, 0);

      // write aborted after 12 bits
      snap();
      spi_frame(12, 24'h813, 10, m);
      check("ab_no_write", wr_cnt - wr_b, 0);
      check("ab_ferr",     fe_cnt - fe_b, 1);
      check("ab_busy",     {31'd0, busy}, 32'd0);

      // 24-bit write frame
      snap();
      spi_frame(24, 24'hBF77FF, 10, m);
      check("long_pulses", wr_cnt - wr_b, 1);
      check("long_addr",   {26'd0, wr_addr}, 32'h3F);
      check("long_data",   {24'd0, wr_data}, 32'h77);
      check("long_miso",   {8'd0, m}, 32'hA50000);
      check("long_no_ferr",fe_cnt - fe_b, 0);

      // reset during DATA of a write, then a clean frame
      snap();
      spi.i_cs_n = 1'b0;
      spi.i_mosi = 1'b1;
      ticks(8);
      spi_clock(12, 24'h815, m);
      check("rr_busy_mid", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rr_write_en", {31'd0, write_en}, 32'd0);
      check("rr_read_en",  {31'd0, read_en},  32'd0);
      check("rr_address",  {26'd0, address},  32'd0);
      check("rr_busy",     {31'd0, busy},     32'd0);
      check("rr_miso_oe",  {31'd0, spi.o_miso_oe}, 32'd0);
      check("rr_miso",     {31'd0, spi.o_miso}, 32'd0);
      ticks(2);
      rst_n = 1'b1;
      ticks(2);
      spi_clock(4, 24'h5, m);
      check("rr_idle_after", {31'd0, busy}, 32'd0);
      spi.i_cs_n = 1'b1;
      ticks(10);
      check("rr_no_write", wr_cnt - wr_b, 0);
      check("rr_no_ferr",  fe_cnt - fe_b, 0);
      snap();
      spi_frame(16, 24'h8211, 10, m);
      check("rr_wr_pulses", wr_cnt - wr_b, 1);
      check("rr_wr_addr",   {26'd0, wr_addr}, 32'h02);
      check("rr_wr_data",   {24'd0, wr_data}, 32'h11);

      // back-to-back with a 4-cycle CS gap
      snap();
      spi_frame(16, 24'h83AA, 4, m1);
      spi_frame(16, 24'h0300, 10, m);
      check("b2b_wr_miso",  {16'd0, m1[15:0]}, 32'hA500);
      check("b2b_rd_miso",  {16'd0, m[15:0]},  32'hA5AA);
      check("b2b_writes",   wr_cnt - wr_b, 1);
      check("b2b_rd_cycles",rd_cnt - rd_b, 2);
      check("b2b_no_ferr",  fe_cnt - fe_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

`default_nettype wire
